mem_arb_2to1: RTL and testbench

- Shares one single-port synchronous SRAM (1-cycle read latency, byte mask) between the core's instruction-fetch port and its data (load/store) port.
- Lets the team run the core from a unified memory.
- Sits between the core and the RAM macro.
- Issues at most one RAM access per cycle, routes read data back to the owning requester, and de-asserts grant to the loser so the core stalls.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_2to1_if.sv | 50 +++++
 rtl/arb_rr2.sv | 28 ++
 rtl/mem_arb_2to1.sv | 96 +++++++++
 tb/tb_mem_arb_2to1.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the 2:1 instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  // Bit positions of each requester inside the req/gnt vectors
  localparam int unsigned IDX_IF = 0;
  localparam int unsigned IDX_D  = 1;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } ram_req_t;

endpackage

// File: rtl/mem_arb_2to1_if.sv
// Core-facing and RAM-facing signal bundle of the 2:1 memory arbiter.
interface mem_arb_2to1_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W,
  parameter int unsigned MASK_W = DATA_W / 8
);

  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [MASK_W-1:0] i_d_mask;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  logic              o_ram_en;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [MASK_W-1:0] o_ram_mask;
  logic [DATA_W-1:0] i_ram_rdata;

  // Arbiter side
  modport slave (
    input  i_if_req, i_if_addr,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_mask,
    input  i_ram_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_mask
  );

  // Core + RAM side
  modport master (
    output i_if_req, i_if_addr,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_mask,
    output i_ram_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_mask
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way one-hot picker: round-robin on contention when MEM_ARB_RR_EN is
// defined, otherwise fixed priority with the data port always winning.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] gnt
);

  // gnt[1] is the data port, gnt[0] the fetch port
  always_comb begin
    gnt = req;
    if (&req) begin
`ifdef MEM_ARB_RR_EN
      gnt = (last == OWNER_D) ? 2'b01 : 2'b10;
`else
      gnt = 2'b10;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last;
  assign unused_last = (last == OWNER_D);
`endif

endmodule

// File: rtl/mem_arb_2to1.sv
// Shares one single-port synchronous SRAM between instruction fetch and data
// ports. Define MEM_ARB_RR_EN for round-robin contention; default is data-first.
module mem_arb_2to1
  import mem_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mem_arb_2to1_if.slave  bus
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  ram_req_t          ram_req;
  owner_e            last_owner, last_owner_nxt;
  owner_e            rd_owner, rd_owner_nxt;
  logic              rd_pend, rd_pend_nxt;
  logic [DATA_W-1:0] if_hold, if_hold_nxt;
  logic [DATA_W-1:0] d_hold, d_hold_nxt;
  logic              if_rvalid;
  logic              d_rvalid;

  // Requests are masked while in reset so nothing reaches the RAM
  assign req = {bus.i_d_req, bus.i_if_req} & {2{rst_n}};

  arb_rr2 u_arb (
    .req  (req),
    .last (last_owner),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner <= OWNER_IF;
      rd_owner   <= OWNER_IF;
      rd_pend    <= 1'b0;
      if_hold    <= '0;
      d_hold     <= '0;
    end else begin
      last_owner <= last_owner_nxt;
      rd_owner   <= rd_owner_nxt;
      rd_pend    <= rd_pend_nxt;
      if_hold    <= if_hold_nxt;
      d_hold     <= d_hold_nxt;
    end
  end

  always_comb begin
    ram_req        = '0;
    last_owner_nxt = last_owner;
    rd_owner_nxt   = rd_owner;
    rd_pend_nxt    = 1'b0;
    if_hold_nxt    = if_hold;
    d_hold_nxt     = d_hold;
    if_rvalid      = rd_pend & (rd_owner == OWNER_IF) & rst_n;
    d_rvalid       = rd_pend & (rd_owner == OWNER_D) & rst_n;

    // Winner's payload onto the RAM; fetches are full-word reads
    if (gnt[IDX_D]) begin
      ram_req.we    = bus.i_d_we;
      ram_req.addr  = bus.i_d_addr;
      ram_req.wdata = bus.i_d_wdata;
      ram_req.mask  = bus.i_d_mask;
    end else if (gnt[IDX_IF]) begin
      ram_req.addr  = bus.i_if_addr;
      ram_req.mask  = '1;
    end

    if (&req) begin
      last_owner_nxt = gnt[IDX_D] ? OWNER_D : OWNER_IF;
    end

    if ((|gnt) && !ram_req.we) begin
      rd_pend_nxt  = 1'b1;
      rd_owner_nxt = gnt[IDX_D] ? OWNER_D : OWNER_IF;
    end

    if (if_rvalid) if_hold_nxt = bus.i_ram_rdata;
    if (d_rvalid)  d_hold_nxt  = bus.i_ram_rdata;
  end

  assign bus.o_if_gnt    = gnt[IDX_IF];
  assign bus.o_d_gnt     = gnt[IDX_D];
  assign bus.o_ram_en    = |gnt;
  assign bus.o_ram_we    = ram_req.we;
  assign bus.o_ram_addr  = ram_req.addr;
  assign bus.o_ram_wdata = ram_req.wdata;
  assign bus.o_ram_mask  = ram_req.mask;

  assign bus.o_if_rvalid = if_rvalid;
  assign bus.o_d_rvalid  = d_rvalid;

  // Returning read data bypasses the hold register in its rvalid cycle
  assign bus.o_if_rdata = !rst_n ? '0 : (if_rvalid ? bus.i_ram_rdata : if_hold);
  assign bus.o_d_rdata  = !rst_n ? '0 : (d_rvalid ? bus.i_ram_rdata : d_hold);

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Bench for mem_arb_2to1: RAM model, queue-driven requesters, a transaction
// model checked every cycle, plus hand-computed directed expectations.
module tb_mem_arb_2to1;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } dreq_t;

  typedef struct {
    bit          own_d;
    logic [31:0] data;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_arb_2to1_if bus ();

  mem_arb_2to1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [29:0] if_q[$];
  dreq_t       d_q[$];
  bit          acc_if = 1'b0;
  bit          acc_d  = 1'b0;

  bit [31:0]   ram_mem[256];
  bit          ram_wr[256];
  logic [31:0] ram_rdata = '0;
  bit [31:0]   ref_mem[256];
  bit          ref_wr[256];

  assign bus.i_ram_rdata = ram_rdata;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h20:   return 32'hAABBCCDD;
      default: return {16'h5A5A, 8'hC3, a};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Synchronous RAM: command sampled mid-cycle, performed at the clock edge
  initial forever begin
    logic        en, we;
    logic [7:0]  a;
    logic [31:0] w, cur;
    logic [3:0]  m;
    @(negedge clk);
    en = bus.o_ram_en; we = bus.o_ram_we; a = bus.o_ram_addr[7:0];
    w  = bus.o_ram_wdata; m = bus.o_ram_mask;
    @(posedge clk);
    if (en === 1'b1) begin
      cur = ram_wr[a] ? ram_mem[a] : init_word(a);
      if (we) begin
        ram_mem[a] = merge(cur, w, m);
        ram_wr[a]  = 1'b1;
      end else begin
        ram_rdata <= cur;
      end
    end
  end

  // Requesters: present queue heads, hold them until accepted
  initial forever begin
    bus.i_if_req  = (if_q.size() != 0);
    bus.i_if_addr = (if_q.size() != 0) ? if_q[0] : '0;
    bus.i_d_req   = (d_q.size() != 0);
    bus.i_d_we    = (d_q.size() != 0) ? d_q[0].we    : 1'b0;
    bus.i_d_addr  = (d_q.size() != 0) ? d_q[0].addr  : '0;
    bus.i_d_wdata = (d_q.size() != 0) ? d_q[0].wdata : '0;
    bus.i_d_mask  = (d_q.size() != 0) ? d_q[0].mask  : '0;
    @(posedge clk);
    #1;
    if (acc_if) void'(if_q.pop_front());
    if (acc_d)  void'(d_q.pop_front());
  end

  // Transaction model and per-cycle compare
  bit          m_last_d = 1'b0;
  logic [31:0] m_hold_if = '0;
  logic [31:0] m_hold_d  = '0;
  rsp_t        rsp_q[$];
  bit          prev_if_wait = 1'b0;
  bit          prev_d_wait  = 1'b0;

  initial forever begin
    bit          ifr, dr, pick_d, eg_if, eg_d, ev_if, ev_d;
    logic [31:0] erd_if, erd_d;
    logic [66:0] exp_pl;
    rsp_t        r;
    @(negedge clk);
    ifr = bus.i_if_req;
    dr  = bus.i_d_req;
    if (!rst_n) begin
      chk("rst_ram_en",    96'(bus.o_ram_en),    96'(0));
      chk("rst_if_rvalid", 96'(bus.o_if_rvalid), 96'(0));
      chk("rst_d_rvalid",  96'(bus.o_d_rvalid),  96'(0));
      chk("rst_if_rdata",  96'(bus.o_if_rdata),  96'(0));
      chk("rst_d_rdata",   96'(bus.o_d_rdata),   96'(0));
      rsp_q.delete();
      m_last_d = 1'b0; m_hold_if = '0; m_hold_d = '0;
      acc_if = 1'b0; acc_d = 1'b0;
      prev_if_wait = 1'b0; prev_d_wait = 1'b0;
    end else begin
      if (prev_if_wait) chk("proto_if_req_held", 96'(ifr), 96'(1));
      if (prev_d_wait)  chk("proto_d_req_held",  96'(dr),  96'(1));
`ifdef MEM_ARB_RR_EN
      pick_d = !m_last_d;
`else
      pick_d = 1'b1;
`endif
      eg_d  = dr && (!ifr || pick_d);
      eg_if = ifr && !eg_d;
      r = '{own_d: 1'b0, data: '0};
      ev_if = 1'b0; ev_d = 1'b0;
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        ev_d  = r.own_d;
        ev_if = !r.own_d;
      end
      erd_if = ev_if ? r.data : m_hold_if;
      erd_d  = ev_d  ? r.data : m_hold_d;
      chk("if_gnt",    96'(bus.o_if_gnt),    96'(eg_if));
      chk("d_gnt",     96'(bus.o_d_gnt),     96'(eg_d));
      chk("ram_en",    96'(bus.o_ram_en),    96'(eg_if | eg_d));
      chk("if_rvalid", 96'(bus.o_if_rvalid), 96'(ev_if));
      chk("d_rvalid",  96'(bus.o_d_rvalid),  96'(ev_d));
      chk("if_rdata",  96'(bus.o_if_rdata),  96'(erd_if));
      chk("d_rdata",   96'(bus.o_d_rdata),   96'(erd_d));
      if (eg_if || eg_d) begin
        exp_pl = eg_d ? {bus.i_d_we, bus.i_d_addr, bus.i_d_wdata, bus.i_d_mask}
                      : {1'b0, bus.i_if_addr, 32'h0, 4'hF};
        chk("ram_payload",
            96'({bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata, bus.o_ram_mask}),
            96'(exp_pl));
      end
      if (ev_if) m_hold_if = r.data;
      if (ev_d)  m_hold_d  = r.data;
      if (eg_d && bus.i_d_we) begin
        ref_mem[bus.i_d_addr[7:0]] = merge(ref_rd(bus.i_d_addr[7:0]), bus.i_d_wdata, bus.i_d_mask);
        ref_wr[bus.i_d_addr[7:0]]  = 1'b1;
      end else if (eg_d) begin
        rsp_q.push_back('{own_d: 1'b1, data: ref_rd(bus.i_d_addr[7:0])});
      end else if (eg_if) begin
        rsp_q.push_back('{own_d: 1'b0, data: ref_rd(bus.i_if_addr[7:0])});
      end
      if (ifr && dr) m_last_d = eg_d;
      acc_if = ifr && (bus.o_if_gnt === 1'b1);
      acc_d  = dr  && (bus.o_d_gnt === 1'b1);
      prev_if_wait = ifr && !acc_if;
      prev_d_wait  = dr  && !acc_d;
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_q.size() == 0 && d_q.size() == 0) break;
    end
    chk("queues_drained", 96'(if_q.size() + d_q.size()), 96'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with both ports requesting
    if_q.push_back(30'h30);
    d_q.push_back('{we: 1'b0, addr: 30'h31, wdata: '0, mask: '0});
    repeat (2) begin
      @(negedge clk);
      chk("reset_ram_en", 96'(bus.o_ram_en), 96'(0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_if_rdata", 96'(bus.o_if_rdata), 96'(0));
    chk("post_reset_d_rdata",  96'(bus.o_d_rdata),  96'(0));
    chk("post_reset_d_first",  96'(bus.o_d_gnt),    96'(1));
    wait_idle(10);

    // Fetch only
    if_q.push_back(30'h10);
    @(negedge clk);
    chk("fetch_gnt_c0", 96'(bus.o_if_gnt), 96'(1));
    @(negedge clk);
    chk("fetch_rvalid_c1", 96'(bus.o_if_rvalid), 96'(1));
    chk("fetch_rdata_c1",  96'(bus.o_if_rdata),  96'(32'hDEADBEEF));
    @(negedge clk);
    chk("fetch_rvalid_c2", 96'(bus.o_if_rvalid), 96'(0));
    @(negedge clk);
    chk("fetch_rdata_c3",  96'(bus.o_if_rdata),  96'(32'hDEADBEEF));
    wait_idle(10);

    // Partial store then load of the same word
    d_q.push_back('{we: 1'b1, addr: 30'h20, wdata: 32'h11223344, mask: 4'b0011});
    d_q.push_back('{we: 1'b0, addr: 30'h20, wdata: '0, mask: '0});
    @(negedge clk);
    chk("store_we_c0",   96'(bus.o_ram_we),   96'(1));
    chk("store_mask_c0", 96'(bus.o_ram_mask), 96'(4'b0011));
    @(negedge clk);
    chk("load_gnt_c1",    96'(bus.o_d_gnt),    96'(1));
    chk("no_rvalid_c1",   96'(bus.o_d_rvalid), 96'(0));
    @(negedge clk);
    chk("load_rvalid_c2", 96'(bus.o_d_rvalid), 96'(1));
    chk("load_rdata_c2",  96'(bus.o_d_rdata),  96'(32'hAABB3344));
    wait_idle(10);

    // Store with an empty mask leaves the word untouched
    d_q.push_back('{we: 1'b1, addr: 30'h40, wdata: 32'hFFFFFFFF, mask: 4'b0000});
    d_q.push_back('{we: 1'b0, addr: 30'h40, wdata: '0, mask: '0});
    @(negedge clk);
    chk("mask0_fwd_c0", 96'(bus.o_ram_mask), 96'(0));
    repeat (2) @(negedge clk);
    chk("mask0_rdata_c2", 96'(bus.o_d_rdata), 96'(32'h5A5AC340));
    wait_idle(10);

    do_reset();

`ifdef MEM_ARB_RR_EN
    // Sustained contention alternates D, IF, D, IF ...
    for (int i = 0; i < 4; i++) begin
      d_q.push_back('{we: 1'b0, addr: 30'(32'h50 + i), wdata: '0, mask: '0});
      if_q.push_back(30'(32'h60 + i));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_d_gnt",  96'(bus.o_d_gnt),  96'(k % 2 == 0));
      chk("rr_if_gnt", 96'(bus.o_if_gnt), 96'(k % 2 == 1));
      if (k > 0) chk("rr_d_rvalid", 96'(bus.o_d_rvalid), 96'((k - 1) % 2 == 0));
    end
    @(negedge clk);
    chk("rr_last_if_rvalid", 96'(bus.o_if_rvalid), 96'(1));
    chk("rr_last_if_rdata",  96'(bus.o_if_rdata),  96'(32'h5A5AC363));
`else
    // Data port keeps priority while it keeps requesting
    for (int i = 0; i < 5; i++)
      d_q.push_back('{we: 1'b0, addr: 30'(32'h50 + i), wdata: '0, mask: '0});
    if_q.push_back(30'h60);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fp_if_stalled", 96'(bus.o_if_gnt), 96'(0));
      chk("fp_d_gnt",      96'(bus.o_d_gnt),  96'(1));
    end
    @(negedge clk);
    chk("fp_if_gnt_c5", 96'(bus.o_if_gnt), 96'(1));
    @(negedge clk);
    chk("fp_if_rvalid_c6", 96'(bus.o_if_rvalid), 96'(1));
    chk("fp_if_rdata_c6",  96'(bus.o_if_rdata),  96'(32'h5A5AC360));
`endif
    wait_idle(20);

    // Reset lands in the cycle after a fetch grant
    if_q.push_back(30'h10);
    @(negedge clk);
    chk("midrst_gnt_c0", 96'(bus.o_if_gnt), 96'(1));
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid_c1", 96'(bus.o_if_rvalid), 96'(0));
    chk("midrst_rdata_c1",  96'(bus.o_if_rdata),  96'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid_c2", 96'(bus.o_if_rvalid), 96'(0));
    chk("midrst_rdata_c2",  96'(bus.o_if_rdata),  96'(0));
    wait_idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
